pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Drives the lden (load-enable) and
//  flush (bubble-insert) inputs of pc, if_id, id_ex, ex_mem and mem_wb. Resolves three hazards:
//   - jump flush
//   - multi-cycle M-extension hold, with start/done handshake to the mul/div unit
//   - load-use bubble
//  Also freezes the pipe on data-memory wait.
// PARAMETERS
//  MUL_LAT  2   extra cycles the EX-stage MUL op is held after md_start
//  DIV_LAT  33  extra cycles the EX-stage DIV/REM op is held after md_start
// PORTS
//  clk          in   1   clock; all state on rising edge
//  rstn         in   1   asynchronous, active-HIGH reset (port name kept per codebase)
//  id_rs1_ren   in   1   ID instruction reads rs1
//  id_rs1_addr  in   5   ID rs1 index
//  id_rs2_ren   in   1   ID instruction reads rs2
//  id_rs2_addr  in   5   ID rs2 index
//  ex_load      in   1   instruction in EX is a load
//  ex_rd_addr   in   5   EX destination index
//  ex_md_req    in   1   instruction in EX is M-ext (level while in EX)
//  ex_md_div    in   1   1=DIV/DIVU/REM/REMU, 0=MUL*
//  ex_jump      in   1   branch taken / jump resolved in EX
//  mem_cs       in   1   MEM stage accessing data memory
//  dmem_ready   in   1   data memory completes access this cycle
//  pc_lden, ifid_lden, idex_lden, exmem_lden, memwb_lden   out  1 each   1=stage advances
//  ifid_flush, idex_flush, exmem_flush, memwb_flush        out  1 each   1=load INST_NOP/zero ctrl
//  md_start     out  1   one-cycle pulse; mul/div unit samples operands
//  md_done      out  1   one-cycle pulse; result valid, EX releases
//  md_busy      out  1   high in MD state
// BEHAVIOUR
//  State and outputs:
//   - FSM {RUN, MD}, down-counter cnt of width $clog2(DIV_LAT+1). Only state/cnt registered; outputs
//     are combinational from state/cnt/inputs.
//   - Reset: state=RUN, cnt=0. While rstn=1 all lden=0, all flush=1, md_* = 0.
//  Flush vs lden: flush=1 forces the bubble load regardless of that stage's lden.
//  Priority, highest first:
//   1 FREEZE: mem_cs & ~dmem_ready.
//     - pc/ifid/idex/exmem lden=0; memwb_flush=1; all else 0.
//     - cnt holds; md_start and md_done suppressed; state unchanged.
//   2 JUMP (RUN, ex_jump): ifid_flush=1, idex_flush=1, all lden=1. Overrides load-use.
//   3 MD_START (RUN, ex_md_req):
//     - md_start=1.
//     - pc/ifid/idex lden=0; exmem_flush=1.
//     - Next: state=MD, cnt = ex_md_div ? DIV_LAT-1 : MUL_LAT-1.
//   4 MD (state MD):
//     - md_busy=1.
//     - cnt!=0: same stall as MD_START; cnt--.
//     - cnt==0: md_done=1, all lden=1, state=RUN.
//   5 LOAD-USE (RUN): ex_load & ex_rd_addr!=0 & ((rs1_ren & rs1==rd) | (rs2_ren & rs2==rd)).
//     - pc/ifid lden=0; idex_flush=1; exactly one bubble.
//   6 else: all lden=1, no flush.
//  Timing and boundaries:
//   - An M op occupies EX for LAT+1 cycles, excluding freeze cycles.
//   - md_done cycle advances id_ex, so the next EX instruction may itself raise ex_md_req:
//     back-to-back M ops restart immediately in RUN with no idle cycle.
//   - ex_jump while in MD cannot occur (EX holds the M op); ignore it.
//   - Freeze on the md_done cycle delays md_done until the freeze ends.
//   - Load-use with ID rd==x0 gives no stall.
//   - Reset asserted mid-MD: immediate RUN, cnt=0, no md_done. The mul/div unit shares rstn.
// STRUCTURE
//  defines.v:
//   - `PIPE_RUN, `PIPE_MD state encodings
//   - `MulLat, `DivLat defaults
//   - reuse `RegAddrBus, `INST_NOP
//  Sub-module pipe_hazard_det (combinational load-use compare, returns ld_use).
//  FSM and counter use gnrl_dfflr-style flops with async active-high reset.
// TESTING
//  - Reset: rstn=1 for 3 clk -> all lden=0, all flush=1; release -> state RUN, all lden=1.
//  - Load-use: ex_load=1, ex_rd=5, id_rs2_ren=1, rs2=5 -> 1 cycle pc/ifid_lden=0, idex_flush=1;
//    same with rd=0 -> no stall.
//  - DIV: ex_md_req=1, ex_md_div=1 -> md_start at t0, md_busy t1..t33, md_done at t33,
//    exmem_flush t0..t32, id_ex advances at t33.
//  - MUL back-to-back: two MULs -> md_start t0, md_done t2, md_start t3, md_done t5.
//  - Jump + load-use same cycle -> ifid_flush=idex_flush=1, pc_lden=1, no stall.
//  - Freeze in MD: dmem_ready=0 for 4 cycles at cnt=3 -> cnt holds; md_done delayed 4 cycles;
//    memwb_flush=1 during the freeze.
//  - Reset mid-DIV at cnt=10 -> state RUN, md_busy=0, no md_done.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
//   PIPE_RUN / PIPE_MD   sequencer state encodings
//   MUL_LAT_DEF          default extra hold cycles for MUL ops
//   DIV_LAT_DEF          default extra hold cycles for DIV/REM ops
//   reg_addr_t           architectural register index
//   src_match()          one source-operand vs destination compare
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W  = 5;
    localparam int MUL_LAT_DEF = 2;
    localparam int DIV_LAT_DEF = 33;

    typedef enum logic {
        PIPE_RUN = 1'b0,
        PIPE_MD  = 1'b1
    } pipe_state_e;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    function automatic logic src_match(input logic      ren,
                                       input reg_addr_t rs,
                                       input reg_addr_t rd);
        return ren && (rs == rd);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_det.sv
// Combinational load-use detector.
//   id_rs1_ren/id_rs1_addr, id_rs2_ren/id_rs2_addr   ID source operands
//   ex_load, ex_rd_addr                              load currently in EX
//   ld_use                                           1 = ID needs the load result
module pipe_ctrl_hazard_det
    import pipe_ctrl_pkg::*;
(
    input  logic      id_rs1_ren,
    input  reg_addr_t id_rs1_addr,
    input  logic      id_rs2_ren,
    input  reg_addr_t id_rs2_addr,
    input  logic      ex_load,
    input  reg_addr_t ex_rd_addr,
    output logic      ld_use
);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign ld_use = ex_load && (ex_rd_addr != '0) &&
                    (src_match(id_rs1_ren, id_rs1_addr, ex_rd_addr) ||
                     src_match(id_rs2_ren, id_rs2_addr, ex_rd_addr));

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Inputs : clk, rstn (async, active-high), ID source operands, EX load/M-op/jump
//          info, MEM data-memory handshake (mem_cs, dmem_ready).
// Outputs: per-stage load enables (*_lden), per-stage bubble inserts (*_flush),
//          mul/div handshake (md_start, md_done, md_busy).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// PIPE_RUN | normal flow; jump flush, load-use bubble, M-op launch
// PIPE_MD  | M-op held in EX; cnt counts remaining hold cycles to 0
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic      clk,
    input  logic      rstn,
    input  logic      id_rs1_ren,
    input  reg_addr_t id_rs1_addr,
    input  logic      id_rs2_ren,
    input  reg_addr_t id_rs2_addr,
    input  logic      ex_load,
    input  reg_addr_t ex_rd_addr,
    input  logic      ex_md_req,
    input  logic      ex_md_div,
    input  logic      ex_jump,
    input  logic      mem_cs,
    input  logic      dmem_ready,
    output logic      pc_lden,
    output logic      ifid_lden,
    output logic      idex_lden,
    output logic      exmem_lden,
    output logic      memwb_lden,
    output logic      ifid_flush,
    output logic      idex_flush,
    output logic      exmem_flush,
    output logic      memwb_flush,
    output logic      md_start,
    output logic      md_done,
    output logic      md_busy
);

    localparam int              CNT_W    = $clog2(DIV_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    pipe_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             freeze;
    logic             ld_use;

    assign freeze = mem_cs && !dmem_ready;

    pipe_ctrl_hazard_det u_hazard_det (
        .id_rs1_ren  (id_rs1_ren),
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_ren  (id_rs2_ren),
        .id_rs2_addr (id_rs2_addr),
        .ex_load     (ex_load),
        .ex_rd_addr  (ex_rd_addr),
        .ld_use      (ld_use)
    );

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state <= PIPE_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A data-memory wait freezes the sequencer completely, so an M op's hold
    // time is measured in unfrozen cycles only.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!freeze) begin
            case (state)
                PIPE_RUN: begin
                    if (!ex_jump && ex_md_req) begin
                        state_nxt = PIPE_MD;
                        cnt_nxt   = ex_md_div ? DIV_LOAD : MUL_LOAD;
                    end
                end
                PIPE_MD: begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end else begin
                        state_nxt = PIPE_RUN;
                    end
                end
                default: begin
                    state_nxt = PIPE_RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        pc_lden     = 1'b1;
        ifid_lden   = 1'b1;
        idex_lden   = 1'b1;
        exmem_lden  = 1'b1;
        memwb_lden  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        md_start    = 1'b0;
        md_done     = 1'b0;
        md_busy     = 1'b0;
        if (rstn) begin
            pc_lden     = 1'b0;
            ifid_lden   = 1'b0;
            idex_lden   = 1'b0;
            exmem_lden  = 1'b0;
            memwb_lden  = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (freeze) begin
            // Everything up to MEM holds; WB receives a bubble.
            pc_lden     = 1'b0;
            ifid_lden   = 1'b0;
            idex_lden   = 1'b0;
            exmem_lden  = 1'b0;
            memwb_lden  = 1'b0;
            memwb_flush = 1'b1;
            md_busy     = (state == PIPE_MD);
        end else if (state == PIPE_MD) begin
            md_busy = 1'b1;
            if (cnt != '0) begin
                pc_lden     = 1'b0;
                ifid_lden   = 1'b0;
                idex_lden   = 1'b0;
                exmem_flush = 1'b1;
            end else begin
                md_done = 1'b1;
            end
        end else if (ex_jump) begin
            // Jump wins over a load-use stall: the dependent instruction is squashed.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (ex_md_req) begin
            md_start    = 1'b1;
            pc_lden     = 1'b0;
            ifid_lden   = 1'b0;
            idex_lden   = 1'b0;
            exmem_flush = 1'b1;
        end else if (ld_use) begin
            pc_lden    = 1'b0;
            ifid_lden  = 1'b0;
            idex_flush = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 33;

    // Output vector layout: [11:7] lden pc,ifid,idex,exmem,memwb
    //                       [6:3]  flush ifid,idex,exmem,memwb
    //                       [2] md_start [1] md_done [0] md_busy
    localparam logic [11:0] O_RST = 12'b00000_1111_000;
    localparam logic [11:0] O_RUN = 12'b11111_0000_000;
    localparam logic [11:0] O_FRZ = 12'b00000_0001_000;
    localparam logic [11:0] O_JMP = 12'b11111_1100_000;
    localparam logic [11:0] O_MDS = 12'b00011_0010_100;
    localparam logic [11:0] O_MDW = 12'b00011_0010_001;
    localparam logic [11:0] O_MDD = 12'b11111_0000_011;
    localparam logic [11:0] O_LU  = 12'b00111_0100_000;

    typedef struct {
        logic       rst;
        logic       jump;
        logic       md_req;
        logic       md_div;
        logic       ld;
        logic [4:0] rd;
        logic       r1e;
        logic [4:0] r1;
        logic       r2e;
        logic [4:0] r2;
        logic       cs;
        logic       rdy;
    } in_t;

    typedef struct {
        in_t         i;
        logic [11:0] o;
        string       name;
    } vec_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic       id_rs1_ren, id_rs2_ren, ex_load, ex_md_req, ex_md_div, ex_jump, mem_cs, dmem_ready;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic       pc_lden, ifid_lden, idex_lden, exmem_lden, memwb_lden;
    logic       ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic       md_start, md_done, md_busy;
    logic [11:0] dut_o;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          md_left = 0;   // remaining held EX cycles of the current M op
    logic [11:0] obs;
    vec_t        tbl[$];

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .rstn(rstn),
        .id_rs1_ren(id_rs1_ren), .id_rs1_addr(id_rs1_addr),
        .id_rs2_ren(id_rs2_ren), .id_rs2_addr(id_rs2_addr),
        .ex_load(ex_load), .ex_rd_addr(ex_rd_addr),
        .ex_md_req(ex_md_req), .ex_md_div(ex_md_div), .ex_jump(ex_jump),
        .mem_cs(mem_cs), .dmem_ready(dmem_ready),
        .pc_lden(pc_lden), .ifid_lden(ifid_lden), .idex_lden(idex_lden),
        .exmem_lden(exmem_lden), .memwb_lden(memwb_lden),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .md_start(md_start), .md_done(md_done), .md_busy(md_busy)
    );

    assign dut_o = {pc_lden, ifid_lden, idex_lden, exmem_lden, memwb_lden,
                    ifid_flush, idex_flush, exmem_flush, memwb_flush,
                    md_start, md_done, md_busy};

    function automatic in_t mk(logic rst, logic jump, logic md_req, logic md_div,
                               logic ld, logic [4:0] rd, logic r1e, logic [4:0] r1,
                               logic r2e, logic [4:0] r2, logic cs, logic rdy);
        in_t v;
        v.rst = rst; v.jump = jump; v.md_req = md_req; v.md_div = md_div;
        v.ld = ld; v.rd = rd; v.r1e = r1e; v.r1 = r1; v.r2e = r2e; v.r2 = r2;
        v.cs = cs; v.rdy = rdy;
        return v;
    endfunction

    // Reference: priority list evaluated on the number of M-op cycles still owed.
    function automatic logic [11:0] model_out(in_t v);
        if (v.rst)                 return O_RST;
        if (v.cs && !v.rdy)        return O_FRZ | {11'b0, md_left > 0};
        if (md_left > 1)           return O_MDW;
        if (md_left == 1)          return O_MDD;
        if (v.jump)                return O_JMP;
        if (v.md_req)              return O_MDS;
        if (v.ld && v.rd != 0 && ((v.r1e && v.r1 == v.rd) || (v.r2e && v.r2 == v.rd)))
            return O_LU;
        return O_RUN;
    endfunction

    task automatic model_step(in_t v);
        if (v.rst)                 md_left = 0;
        else if (v.cs && !v.rdy)   md_left = md_left;
        else if (md_left > 0)      md_left = md_left - 1;
        else if (v.jump)           md_left = 0;
        else if (v.md_req)         md_left = v.md_div ? DIV_LAT : MUL_LAT;
    endtask

    task automatic check_vec(string name, logic [11:0] act, logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, compare 1 time unit later, advance model.
    task automatic run(in_t v, logic use_model, logic [11:0] exp_tbl, string name);
        logic [11:0] exp;
        @(negedge clk);
        rstn = v.rst; ex_jump = v.jump; ex_md_req = v.md_req; ex_md_div = v.md_div;
        ex_load = v.ld; ex_rd_addr = v.rd; id_rs1_ren = v.r1e; id_rs1_addr = v.r1;
        id_rs2_ren = v.r2e; id_rs2_addr = v.r2; mem_cs = v.cs; dmem_ready = v.rdy;
        #1;
        exp = use_model ? model_out(v) : exp_tbl;
        obs = dut_o;
        check_vec(name, obs, exp);
        model_step(v);
        cyc++;
    endtask

    function automatic in_t idle();
        return mk(0,0,0,0, 0,5'd0, 0,5'd0, 0,5'd0, 0,1);
    endfunction

    function automatic in_t mdop(logic div, logic frz);
        return mk(0,0,1,div, 0,5'd0, 0,5'd0, 0,5'd0, frz,!frz);
    endfunction

    initial begin
        int t_start, t_done, n_start, n_done, n_busy, n_xf;
        logic [5:0] sp, dp;
        in_t v;

        rstn = 1'b1; ex_jump = 0; ex_md_req = 0; ex_md_div = 0; ex_load = 0;
        ex_rd_addr = 0; id_rs1_ren = 0; id_rs1_addr = 0; id_rs2_ren = 0;
        id_rs2_addr = 0; mem_cs = 0; dmem_ready = 1;

        //                rst jmp mdr div ld  rd    r1e r1    r2e r2    cs rdy
        tbl.push_back('{mk(1,0,0,0, 0,5'd0, 0,5'd0, 0,5'd0, 0,1), O_RST, "reset0"});
        tbl.push_back('{mk(1,0,0,0, 0,5'd0, 0,5'd0, 0,5'd0, 0,1), O_RST, "reset1"});
        tbl.push_back('{mk(1,0,1,1, 1,5'd5, 1,5'd5, 0,5'd0, 1,0), O_RST, "reset2"});
        tbl.push_back('{mk(0,0,0,0, 0,5'd0, 0,5'd0, 0,5'd0, 0,1), O_RUN, "released"});
        tbl.push_back('{mk(0,0,0,0, 1,5'd5, 0,5'd0, 1,5'd5, 0,1), O_LU,  "lu_rs2"});
        tbl.push_back('{mk(0,0,0,0, 0,5'd0, 0,5'd0, 1,5'd5, 0,1), O_RUN, "lu_one_bubble"});
        tbl.push_back('{mk(0,0,0,0, 1,5'd0, 1,5'd0, 1,5'd0, 0,1), O_RUN, "lu_rd_x0"});
        tbl.push_back('{mk(0,0,0,0, 1,5'd7, 1,5'd7, 0,5'd0, 0,1), O_LU,  "lu_rs1"});
        tbl.push_back('{mk(0,0,0,0, 1,5'd5, 0,5'd5, 0,5'd5, 0,1), O_RUN, "lu_no_ren"});
        tbl.push_back('{mk(0,0,0,0, 1,5'd5, 1,5'd4, 1,5'd6, 0,1), O_RUN, "lu_addr_miss"});
        tbl.push_back('{mk(0,0,0,0, 0,5'd5, 1,5'd5, 1,5'd5, 0,1), O_RUN, "no_load"});
        tbl.push_back('{mk(0,1,0,0, 1,5'd5, 0,5'd0, 1,5'd5, 0,1), O_JMP, "jump_over_lu"});
        tbl.push_back('{mk(0,0,0,0, 0,5'd0, 0,5'd0, 0,5'd0, 1,0), O_FRZ, "freeze"});
        tbl.push_back('{mk(0,1,0,0, 0,5'd0, 0,5'd0, 0,5'd0, 1,0), O_FRZ, "freeze_jump"});
        tbl.push_back('{mk(0,0,1,1, 0,5'd0, 0,5'd0, 0,5'd0, 1,0), O_FRZ, "freeze_mdreq"});
        tbl.push_back('{mk(0,0,0,0, 1,5'd3, 1,5'd3, 0,5'd0, 1,0), O_FRZ, "freeze_lu"});
        tbl.push_back('{mk(0,0,0,0, 0,5'd0, 0,5'd0, 0,5'd0, 1,1), O_RUN, "mem_ready"});

        foreach (tbl[k]) run(tbl[k].i, 1'b0, tbl[k].o, tbl[k].name);

        // DIV: start t0, busy t1..t33, done t33, exmem_flush t0..t32.
        t_start = -1; t_done = -1; n_start = 0; n_busy = 0; n_xf = 0;
        for (int t = 0; t < 34; t++) begin
            run(mdop(1'b1, 1'b0), 1'b1, '0, "div_seq");
            if (obs[2]) begin n_start++; if (t_start < 0) t_start = t; end
            if (obs[1] && t_done < 0) t_done = t;
            if (obs[0]) n_busy++;
            if (obs[4]) n_xf++;
        end
        check_int("div_start_t", t_start, 0);
        check_int("div_start_cnt", n_start, 1);
        check_int("div_done_t", t_done, 33);
        check_int("div_busy_cycles", n_busy, 33);
        check_int("div_exmem_flush_cycles", n_xf, 33);
        run(idle(), 1'b1, '0, "div_after");

        // Back-to-back MULs.
        sp = '0; dp = '0;
        for (int t = 0; t < 6; t++) begin
            run(mdop(1'b0, 1'b0), 1'b1, '0, "mul_b2b");
            sp[t] = obs[2];
            dp[t] = obs[1];
        end
        check_int("mul_b2b_start_pattern", int'(sp), int'(6'b001001));
        check_int("mul_b2b_done_pattern", int'(dp), int'(6'b100100));
        run(idle(), 1'b1, '0, "mul_after");

        // Freeze for 4 cycles when 3 hold cycles remain: done moves from t33 to t37.
        t_done = -1; n_start = 0;
        for (int t = 0; t < 38; t++) begin
            run(mdop(1'b1, (t >= 30 && t <= 33)), 1'b1, '0, "div_freeze");
            if (obs[2]) n_start++;
            if (obs[1] && t_done < 0) t_done = t;
            if (t >= 30 && t <= 33) check_vec("div_freeze_out", obs, 12'b00000_0001_001);
        end
        check_int("div_freeze_done_t", t_done, 37);
        check_int("div_freeze_start_cnt", n_start, 1);
        run(idle(), 1'b1, '0, "freeze_after");

        // Reset mid-DIV with 10 hold cycles left.
        for (int t = 0; t < 23; t++) run(mdop(1'b1, 1'b0), 1'b1, '0, "div_pre_rst");
        v = mdop(1'b1, 1'b0);
        v.rst = 1'b1;
        run(v, 1'b1, '0, "div_rst");
        n_done = 0;
        for (int t = 0; t < 12; t++) begin
            run(idle(), 1'b1, '0, "div_post_rst");
            if (obs[1]) n_done++;
            if (t == 0) check_vec("post_rst_run", obs, O_RUN);
        end
        check_int("post_rst_no_done", n_done, 0);

        // Random traffic against the reference model.
        for (int n = 0; n < 4000; n++) begin
            v.rst    = ($urandom_range(0, 199) == 0);
            v.jump   = ($urandom_range(0, 9) == 0);
            v.md_req = ($urandom_range(0, 7) == 0);
            v.md_div = ($urandom_range(0, 3) == 0);
            v.ld     = $urandom_range(0, 1);
            v.rd     = 5'($urandom_range(0, 3));
            v.r1e    = $urandom_range(0, 1);
            v.r1     = 5'($urandom_range(0, 3));
            v.r2e    = $urandom_range(0, 1);
            v.r2     = 5'($urandom_range(0, 3));
            v.cs     = $urandom_range(0, 1);
            v.rdy    = ($urandom_range(0, 2) != 0);
            run(v, 1'b1, '0, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
